// File: rtl/ram_control.sv
// In-place radix-2 DIT FFT sequencer: reads issue 1 cycle after start, twiddles 1 cycle later, write-back 2 cycles after the read.
// No backpressure: once started it walks every stage at one butterfly per cycle, with a 2-cycle gap between stages.
module ram_control #(
  parameter int L_max = 3,
  parameter int N     = 2 ** L_max
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    initial_flag,
  output logic                    wr_en,
  output logic [L_max-1:0]        wr_add1,
  output logic [L_max-1:0]        wr_add2,
  output logic                    rd_en,
  output logic [L_max-1:0]        rd_add1,
  output logic [L_max-1:0]        rd_add2,
  output logic signed [15:0]      factor_re,
  output logic signed [15:0]      factor_im,
  output logic                    en_multi,
  output logic                    flag_fftfinish
);

  localparam int KW = L_max - 1;
  localparam int SW = (L_max > 1) ? $clog2(L_max) : 1;
  localparam logic [L_max-1:0] ONE = {{(L_max-1){1'b0}}, 1'b1};
  localparam real PI = 3.14159265358979323846;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  // Round half away from zero into Q1.14.
  function automatic logic signed [15:0] q14(input real x);
    real r;
    r = (x >= 0.0) ? x + 0.5 : x - 0.5;
    return 16'($rtoi(r));
  endfunction

  logic signed [15:0] tw_re [N/2];
  logic signed [15:0] tw_im [N/2];

  for (genvar g = 0; g < N/2; g++) begin : g_tw
    localparam logic signed [15:0] RE = q14(16384.0 * $cos(2.0 * PI * g / N));
    localparam logic signed [15:0] IM = q14(-16384.0 * $sin(2.0 * PI * g / N));
    assign tw_re[g] = RE;
    assign tw_im[g] = IM;
  end

  state_t            state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [KW-1:0]     k_q, k_d;
  logic              drain_q, drain_d;
  logic [KW-1:0]     j_q, j_d;

  logic              rd_en_q, rd_en_d;
  logic [L_max-1:0]  rd_add1_q, rd_add1_d, rd_add2_q, rd_add2_d;
  logic              en_multi_q, en_multi_d;
  logic signed [15:0] factor_re_q, factor_re_d, factor_im_q, factor_im_d;
  logic              p_vld_q, p_vld_d;
  logic [L_max-1:0]  p_add1_q, p_add1_d, p_add2_q, p_add2_d;
  logic              wr_en_q, wr_en_d;
  logic [L_max-1:0]  wr_add1_q, wr_add1_d, wr_add2_q, wr_add2_d;
  logic              fin_q, fin_d;

  logic [L_max-1:0]  kx, span, pos, grp, add1;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (initial_flag) begin
          state_d = READ;
          s_d     = '0;
          k_d     = '0;
        end
      end
      READ: begin
        if (&k_q) begin
          state_d = DRAIN;
          drain_d = 1'b0;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q) begin
          if (s_q == SW'(L_max - 1)) begin
            state_d = FINISH;
          end else begin
            state_d = READ;
            s_d     = s_q + 1'b1;
            k_d     = '0;
          end
        end else begin
          drain_d = 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so that they register in step with it.
  always_comb begin
    kx   = {1'b0, k_d};
    span = ONE << s_d;
    pos  = kx & (span - ONE);
    grp  = kx >> s_d;
    add1 = ((grp << s_d) << 1) | pos;
    j_d  = pos[KW-1:0] << (SW'(L_max - 1) - s_d);

    rd_en_d   = (state_d == READ);
    rd_add1_d = rd_en_d ? add1 : '0;
    rd_add2_d = rd_en_d ? (add1 | span) : '0;

    en_multi_d  = rd_en_q;
    factor_re_d = rd_en_q ? tw_re[j_q] : '0;
    factor_im_d = rd_en_q ? tw_im[j_q] : '0;

    p_vld_d   = rd_en_q;
    p_add1_d  = rd_add1_q;
    p_add2_d  = rd_add2_q;
    wr_en_d   = p_vld_q;
    wr_add1_d = p_add1_q;
    wr_add2_d = p_add2_q;

    fin_d = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      k_q         <= '0;
      drain_q     <= 1'b0;
      j_q         <= '0;
      rd_en_q     <= 1'b0;
      rd_add1_q   <= '0;
      rd_add2_q   <= '0;
      en_multi_q  <= 1'b0;
      factor_re_q <= '0;
      factor_im_q <= '0;
      p_vld_q     <= 1'b0;
      p_add1_q    <= '0;
      p_add2_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_add1_q   <= '0;
      wr_add2_q   <= '0;
      fin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      k_q         <= k_d;
      drain_q     <= drain_d;
      j_q         <= j_d;
      rd_en_q     <= rd_en_d;
      rd_add1_q   <= rd_add1_d;
      rd_add2_q   <= rd_add2_d;
      en_multi_q  <= en_multi_d;
      factor_re_q <= factor_re_d;
      factor_im_q <= factor_im_d;
      p_vld_q     <= p_vld_d;
      p_add1_q    <= p_add1_d;
      p_add2_q    <= p_add2_d;
      wr_en_q     <= wr_en_d;
      wr_add1_q   <= wr_add1_d;
      wr_add2_q   <= wr_add2_d;
      fin_q       <= fin_d;
    end
  end

  assign rd_en          = rd_en_q;
  assign rd_add1        = rd_add1_q;
  assign rd_add2        = rd_add2_q;
  assign en_multi       = en_multi_q;
  assign factor_re      = factor_re_q;
  assign factor_im      = factor_im_q;
  assign wr_en          = wr_en_q;
  assign wr_add1        = wr_add1_q;
  assign wr_add2        = wr_add2_q;
  assign flag_fftfinish = fin_q;

endmodule

// File: tb/tb_ram_control.sv
// Bench for ram_control (N=8): cycle-indexed reference model plus literal spot checks.
module tb_ram_control;
  localparam int L    = 3;
  localparam int N    = 8;
  localparam int H    = N / 2;
  localparam int P    = H + 2;
  localparam int LAST = L * P + 1;
  localparam int TW_RE_EXP [H] = '{16384, 11585, 0, -11585};
  localparam int TW_IM_EXP [H] = '{0, -11585, -16384, -11585};

  typedef struct {
    int rd_en, rd1, rd2, em, fre, fim, wr_en, wr1, wr2, fin;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic initial_flag = 1'b0;
  logic wr_en, rd_en, en_multi, flag_fftfinish;
  logic [L-1:0] wr_add1, wr_add2, rd_add1, rd_add2;
  logic signed [15:0] factor_re, factor_im;

  ram_control #(.L_max(L), .N(N)) dut (
    .clk(clk), .rst(rst), .initial_flag(initial_flag),
    .wr_en(wr_en), .wr_add1(wr_add1), .wr_add2(wr_add2),
    .rd_en(rd_en), .rd_add1(rd_add1), .rd_add2(rd_add2),
    .factor_re(factor_re), .factor_im(factor_im),
    .en_multi(en_multi), .flag_fftfinish(flag_fftfinish)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int mt = -1;      // index of the current cycle within a run (start sampled in cycle 0), -1 when idle
  bit done = 1'b0;
  obs_t lg [32];

  task automatic chk(input string nm, input int t, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, t, act, exp);
    end
  endtask

  function automatic bit is_read(input int t, output int s, output int k);
    s = 0;
    k = 0;
    if (t < 1 || t > L * P) return 1'b0;
    s = (t - 1) / P;
    k = (t - 1) % P;
    return k < H;
  endfunction

  function automatic obs_t expect_at(input int t);
    obs_t e;
    int s, k, span, j;
    e = '{default: 0};
    if (t < 0) return e;
    if (is_read(t, s, k)) begin
      span = 2 ** s;
      e.rd_en = 1;
      e.rd1 = (k / span) * 2 * span + k % span;
      e.rd2 = e.rd1 + span;
    end
    if (is_read(t - 1, s, k)) begin
      span = 2 ** s;
      j = (k % span) * 2 ** (L - 1 - s);
      e.em = 1;
      e.fre = TW_RE_EXP[j];
      e.fim = TW_IM_EXP[j];
    end
    if (is_read(t - 2, s, k)) begin
      span = 2 ** s;
      e.wr_en = 1;
      e.wr1 = (k / span) * 2 * span + k % span;
      e.wr2 = e.wr1 + span;
    end
    e.fin = (t == LAST) ? 1 : 0;
    return e;
  endfunction

  function automatic obs_t actual();
    obs_t a;
    a.rd_en = int'(rd_en);
    a.rd1   = int'(rd_add1);
    a.rd2   = int'(rd_add2);
    a.em    = int'(en_multi);
    a.fre   = int'(factor_re);
    a.fim   = int'(factor_im);
    a.wr_en = int'(wr_en);
    a.wr1   = int'(wr_add1);
    a.wr2   = int'(wr_add2);
    a.fin   = int'(flag_fftfinish);
    return a;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) mt = -1;
    else if (mt < 0) begin
      if (initial_flag) mt = 1;
    end else if (mt == LAST) mt = -1;
    else mt = mt + 1;
  end

  always @(negedge clk) begin
    obs_t e, a;
    if (!done) begin
      e = expect_at(mt);
      a = actual();
      if (mt >= 1 && mt < 32) lg[mt] = a;
      chk("rd_en", mt, a.rd_en, e.rd_en);
      chk("rd_add1", mt, a.rd1, e.rd1);
      chk("rd_add2", mt, a.rd2, e.rd2);
      chk("en_multi", mt, a.em, e.em);
      chk("factor_re", mt, a.fre, e.fre);
      chk("factor_im", mt, a.fim, e.fim);
      chk("wr_en", mt, a.wr_en, e.wr_en);
      chk("wr_add1", mt, a.wr1, e.wr1);
      chk("wr_add2", mt, a.wr2, e.wr2);
      chk("flag_fftfinish", mt, a.fin, e.fin);
    end
  end

  task automatic start_pulse();
    @(negedge clk);
    #2 initial_flag = 1'b1;
    @(negedge clk);
    #2 initial_flag = 1'b0;
  endtask

  task automatic wait_finish(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (flag_fftfinish) seen = 1'b1;
    end
    chk(nm, -1, int'(seen), 1);
  endtask

  function automatic int out_or();
    return int'(rd_en | wr_en | en_multi | flag_fftfinish | (|rd_add1) | (|rd_add2) |
                (|wr_add1) | (|wr_add2) | (|factor_re) | (|factor_im));
  endfunction

  initial begin
    // Reset held with the start input toggling.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2 initial_flag = ~initial_flag;
    end
    #1 chk("reset_outputs_zero", -1, out_or(), 0);
    initial_flag = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);

    // Clean run, then pin the model with literal values.
    start_pulse();
    wait_finish("finish_run1");
    chk("lit_rd_c1_a1", 1, lg[1].rd1, 0);
    chk("lit_rd_c1_a2", 1, lg[1].rd2, 1);
    chk("lit_rd_c4_a1", 4, lg[4].rd1, 6);
    chk("lit_rd_c4_a2", 4, lg[4].rd2, 7);
    chk("lit_rd_en_c5", 5, lg[5].rd_en, 0);
    chk("lit_rd_c8_a1", 8, lg[8].rd1, 1);
    chk("lit_rd_c8_a2", 8, lg[8].rd2, 3);
    chk("lit_rd_c10_a2", 10, lg[10].rd2, 7);
    chk("lit_rd_c14_a2", 14, lg[14].rd2, 5);
    chk("lit_fac_c2_re", 2, lg[2].fre, 16384);
    chk("lit_fac_c2_im", 2, lg[2].fim, 0);
    chk("lit_fac_c9_re", 9, lg[9].fre, 0);
    chk("lit_fac_c9_im", 9, lg[9].fim, -16384);
    chk("lit_fac_c15_re", 15, lg[15].fre, 11585);
    chk("lit_fac_c17_re", 17, lg[17].fre, -11585);
    chk("lit_fac_c17_im", 17, lg[17].fim, -11585);
    chk("lit_wr_c16_a1", 16, lg[16].wr1, 1);
    chk("lit_wr_c16_a2", 16, lg[16].wr2, 5);
    chk("lit_wr_en_c6", 6, lg[6].wr_en, 1);
    chk("lit_wr_en_c7", 7, lg[7].wr_en, 0);
    chk("lit_rd_en_c7", 7, lg[7].rd_en, 1);
    chk("lit_fin_c18", 18, lg[18].fin, 0);
    chk("lit_fin_c19", 19, lg[19].fin, 1);
    repeat (3) @(negedge clk);

    // Start pulse repeated mid-run must be ignored.
    start_pulse();
    repeat (4) @(negedge clk);
    #2 initial_flag = 1'b1;
    @(negedge clk);
    #2 initial_flag = 1'b0;
    wait_finish("finish_midpulse");
    repeat (3) @(negedge clk);

    // Reset dropped in cycle 8 aborts immediately.
    start_pulse();
    repeat (7) @(negedge clk);
    #2 chk("pre_reset_rd_en", 8, int'(rd_en), 1);
    rst = 1'b0;
    #1 chk("abort_outputs_zero", 8, out_or(), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (12) @(negedge clk);

    // Restart after the abort, then back-to-back restart right after FINISH.
    start_pulse();
    wait_finish("finish_restart");
    start_pulse();
    wait_finish("finish_backtoback");
    repeat (4) @(negedge clk);

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout cycle=-1 actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
